// File: rtl/bullet_judge_if.sv
// Signal bundle between bullet_judge and the surrounding game / VGA logic.
interface bullet_judge_if;
  logic       move_tick;
  logic       fire;
  logic [9:0] plane_x;
  logic [9:0] plane_y;
  logic [9:0] enemy_x;
  logic [9:0] enemy_y;
  logic       enemyplane_exist;
  logic [9:0] x;
  logic [9:0] y;
  logic       boom;
  logic       bullet_en;
  logic [7:0] hit_count;

  modport master (
    output move_tick, fire, plane_x, plane_y, enemy_x, enemy_y, enemyplane_exist, x, y,
    input  boom, bullet_en, hit_count
  );

  modport slave (
    input  move_tick, fire, plane_x, plane_y, enemy_x, enemy_y, enemyplane_exist, x, y,
    output boom, bullet_en, hit_count
  );
endinterface

// File: rtl/bullet_judge.sv
// Player bullets: launch from the plane, climb on move ticks, hit-test the enemy box, drive boom.
// Optional macro AUTO_FIRE_EN: holding fire relaunches whenever the cooldown expires.
module bullet_judge #(
  parameter int NUM_BULLETS   = 4,
  parameter int BULLET_W      = 4,
  parameter int BULLET_H      = 10,
  parameter int BULLET_SPEED  = 4,
  parameter int ENEMY_W       = 50,
  parameter int ENEMY_H       = 50,
  parameter int PLANE_W       = 50,
  parameter int FIRE_COOLDOWN = 8,
  parameter int BOOM_HOLD     = 16
) (
  input  logic          clk,
  input  logic          rst,
  bullet_judge_if.slave bus
);
  localparam int CD_W   = $clog2(FIRE_COOLDOWN + 1);
  localparam int BC_W   = $clog2(BOOM_HOLD);
  localparam int SLOT_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

  localparam logic [10:0]     BW        = 11'(BULLET_W);
  localparam logic [10:0]     BH        = 11'(BULLET_H);
  localparam logic [10:0]     EW        = 11'(ENEMY_W);
  localparam logic [10:0]     EH        = 11'(ENEMY_H);
  localparam logic [9:0]      SPEED10   = 10'(BULLET_SPEED);
  localparam logic [9:0]      BH10      = 10'(BULLET_H);
  localparam logic [10:0]     SPAWN_DX  = 11'(PLANE_W / 2 - BULLET_W / 2);
  localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(FIRE_COOLDOWN);
  localparam logic [BC_W-1:0] BOOM_LOAD = BC_W'(BOOM_HOLD - 1);

  typedef enum logic {B_IDLE, B_BOOM} boom_state_t;

  boom_state_t             boom_state;
  logic [BC_W-1:0]         boom_cnt;
  logic                    boom_q;
  logic [7:0]              hits_q;
  logic                    fire_q;
  logic                    req;
  logic [CD_W-1:0]         cooldown;
  logic [NUM_BULLETS-1:0]  fly;
  logic [10:0]             bx [NUM_BULLETS];
  logic [9:0]              by [NUM_BULLETS];

  logic                    rise;
  logic                    want;
  logic                    launch_ok;
  logic                    do_launch;
  logic                    have_free;
  logic                    any_hit;
  logic                    en;
  logic [SLOT_W-1:0]       free_idx;
  logic [CD_W-1:0]         cd_next;
  logic [10:0]             spawn_x;
  logic [NUM_BULLETS-1:0]  exits;
  logic [NUM_BULLETS-1:0]  moving;
  logic [NUM_BULLETS-1:0]  hit_vec;
  logic [NUM_BULLETS-1:0]  launch_mask;
  logic [9:0]              by_mv [NUM_BULLETS];

  // All box tests are widened to 11 bits so corner + size never wraps.
  function automatic logic overlaps_enemy(input logic [10:0] bx11, input logic [9:0] by10,
                                          input logic [9:0] ex, input logic [9:0] ey);
    logic [10:0] by11;
    logic [10:0] ex11;
    logic [10:0] ey11;
    by11 = {1'b0, by10};
    ex11 = {1'b0, ex};
    ey11 = {1'b0, ey};
    return (bx11 < ex11 + EW) && (bx11 + BW > ex11) &&
           (by11 < ey11 + EH) && (by11 + BH > ey11);
  endfunction

  function automatic logic covers_pixel(input logic [10:0] bx11, input logic [9:0] by10,
                                        input logic [9:0] px, input logic [9:0] py);
    logic [10:0] px11;
    logic [10:0] py11;
    logic [10:0] by11;
    px11 = {1'b0, px};
    py11 = {1'b0, py};
    by11 = {1'b0, by10};
    return (px11 >= bx11) && (px11 < bx11 + BW) && (py11 >= by11) && (py11 < by11 + BH);
  endfunction

  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!fly[i]) begin
        have_free = 1'b1;
        free_idx  = SLOT_W'(i);
      end
    end
  end

  assign rise = bus.fire && !fire_q;
`ifdef AUTO_FIRE_EN
  assign want = req || bus.fire;
`else
  assign want = req || rise;
`endif
  // A launch is allowed on the tick where the cooldown runs out, giving FIRE_COOLDOWN-tick spacing.
  assign cd_next   = (cooldown == '0) ? '0 : cooldown - CD_W'(1);
  assign launch_ok = bus.move_tick && want && (cd_next == '0) && have_free;
  assign do_launch = launch_ok && (bus.plane_y >= BH10);
  assign spawn_x   = {1'b0, bus.plane_x} + SPAWN_DX;

  always_comb begin
    exits       = '0;
    moving      = '0;
    hit_vec     = '0;
    launch_mask = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      by_mv[i]   = by[i] - SPEED10;
      exits[i]   = fly[i] && (by[i] < SPEED10);
      moving[i]  = fly[i] && !exits[i];
      hit_vec[i] = bus.move_tick && moving[i] && bus.enemyplane_exist &&
                   (boom_state == B_IDLE) &&
                   overlaps_enemy(bx[i], by_mv[i], bus.enemy_x, bus.enemy_y);
    end
    if (do_launch) launch_mask[free_idx] = 1'b1;
  end

  assign any_hit = |hit_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_q   <= 1'b1;
      req      <= 1'b0;
      cooldown <= '0;
      fly      <= '0;
      hits_q   <= '0;
    end else begin
      fire_q <= bus.fire;
      if (launch_ok)  req <= 1'b0;
      else if (rise)  req <= 1'b1;
      if (bus.move_tick) begin
        cooldown <= do_launch ? CD_LOAD : cd_next;
        fly      <= (moving & ~hit_vec) | launch_mask;
        if (any_hit && hits_q != 8'hFF) hits_q <= hits_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      boom_state <= B_IDLE;
      boom_cnt   <= '0;
      boom_q     <= 1'b0;
    end else if (bus.move_tick) begin
      case (boom_state)
        B_IDLE: if (any_hit) begin
          boom_state <= B_BOOM;
          boom_cnt   <= BOOM_LOAD;
          boom_q     <= 1'b1;
        end
        B_BOOM: if (boom_cnt == '0) begin
          boom_state <= B_IDLE;
          boom_q     <= 1'b0;
        end else begin
          boom_cnt <= boom_cnt - BC_W'(1);
        end
        default: boom_state <= B_IDLE;
      endcase
    end
  end

  // Positions carry no reset: a slot's coordinates only matter while it is flying.
  always_ff @(posedge clk) begin
    if (bus.move_tick) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (launch_mask[i]) begin
          bx[i] <= spawn_x;
          by[i] <= bus.plane_y - BH10;
        end else if (moving[i]) begin
          by[i] <= by_mv[i];
        end
      end
    end
  end

  always_comb begin
    en = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (fly[i] && covers_pixel(bx[i], by[i], bus.x, bus.y)) en = 1'b1;
    end
  end

  assign bus.bullet_en = en;
  assign bus.boom      = boom_q;
  assign bus.hit_count = hits_q;
endmodule

// File: tb/tb_bullet_judge.sv
// Randomized and directed bench for bullet_judge against a slot-list reference model.
module tb_bullet_judge;
  localparam int NB = 4, BW = 4, BH = 10, SPD = 4, EW = 50, EH = 50, PW = 50, FC = 8, BHOLD = 16;

  logic clk = 1'b0;
  logic rst;
  bullet_judge_if bus();

  bullet_judge #(.NUM_BULLETS(NB), .BULLET_W(BW), .BULLET_H(BH), .BULLET_SPEED(SPD),
                 .ENEMY_W(EW), .ENEMY_H(EH), .PLANE_W(PW), .FIRE_COOLDOWN(FC),
                 .BOOM_HOLD(BHOLD)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_tick = 0;

  // Reference state: a list of slots with plain integer coordinates.
  int m_fly [NB];
  int m_bx  [NB];
  int m_by  [NB];
  int m_cd, m_boom_left, m_hits;
  bit m_req, m_fire_q;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_fly[i] = 0; m_bx[i] = 0; m_by[i] = 0;
    end
    m_cd = 0; m_boom_left = 0; m_hits = 0; m_req = 0; m_fire_q = 1;
  endfunction

  function automatic bit model_en(input int px, input int py);
    for (int i = 0; i < NB; i++)
      if (m_fly[i] != 0 && px >= m_bx[i] && px < m_bx[i] + BW && py >= m_by[i] && py < m_by[i] + BH)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_step();
    bit rise, want, boom_act;
    int lowest_free, cd_after, nhit, ex, ey;
    rise = bus.fire && !m_fire_q;
    m_fire_q = bus.fire;
    if (!bus.move_tick) begin
      if (rise) m_req = 1;
      return;
    end
    lowest_free = -1;
    for (int i = NB - 1; i >= 0; i--) if (m_fly[i] == 0) lowest_free = i;
    cd_after = (m_cd > 0) ? m_cd - 1 : 0;
    boom_act = (m_boom_left > 0);
    ex = int'(bus.enemy_x);
    ey = int'(bus.enemy_y);
    nhit = 0;
    for (int i = 0; i < NB; i++) begin
      if (m_fly[i] != 0) begin
        if (m_by[i] < SPD) m_fly[i] = 0;
        else begin
          m_by[i] -= SPD;
          if (!boom_act && bus.enemyplane_exist &&
              m_bx[i] < ex + EW && m_bx[i] + BW > ex && m_by[i] < ey + EH && m_by[i] + BH > ey) begin
            m_fly[i] = 0;
            nhit++;
          end
        end
      end
    end
    if (boom_act) m_boom_left--;
    else if (nhit > 0) m_boom_left = BHOLD;
    if (nhit > 0 && m_hits < 255) m_hits++;
    want = m_req || rise;
`ifdef AUTO_FIRE_EN
    want = want || bus.fire;
`endif
    if (want && cd_after == 0 && lowest_free >= 0) begin
      m_req = 0;
      if (int'(bus.plane_y) >= BH) begin
        m_fly[lowest_free] = 1;
        m_bx[lowest_free] = int'(bus.plane_x) + PW / 2 - BW / 2;
        m_by[lowest_free] = int'(bus.plane_y) - BH;
        m_cd = FC;
      end else m_cd = cd_after;
    end else begin
      m_cd = cd_after;
      if (rise) m_req = 1;
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else model_step();
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      check("boom", int'(bus.boom), int'(m_boom_left > 0));
      check("hit_count", int'(bus.hit_count), m_hits);
      check("bullet_en", int'(bus.bullet_en), int'(model_en(int'(bus.x), int'(bus.y))));
    end
  end

  initial begin
    #5_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk); bus.move_tick = 1'b1;
    @(negedge clk); bus.move_tick = 1'b0;
    n_tick++;
  endtask

  task automatic press();
    @(negedge clk); bus.fire = 1'b1;
    @(negedge clk); bus.fire = 1'b0;
    @(negedge clk);
  endtask

  task automatic probe(input string name, input int px, input int py, input int exp);
    bus.x = 10'(px);
    bus.y = 10'(py);
    #1;
    check(name, int'(bus.bullet_en), exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; bus.move_tick = 1'b0; bus.fire = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_tick = 0;
  endtask

  function automatic logic [9:0] clip10(input int v);
    if (v < 0) return 10'd0;
    if (v > 1023) return 10'd1023;
    return 10'(v);
  endfunction

  initial begin
    int k, nb, r;
    rst = 1'b0;
    bus.move_tick = 0; bus.fire = 1; bus.plane_x = 300; bus.plane_y = 400;
    bus.enemy_x = 300; bus.enemy_y = 200; bus.enemyplane_exist = 0; bus.x = 0; bus.y = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("rst_boom", int'(bus.boom), 0);
    check("rst_hits", int'(bus.hit_count), 0);
    repeat (3) tick();
`ifndef AUTO_FIRE_EN
    probe("held_fire_no_launch", 323, 395, 0);
`endif
    bus.fire = 0;

    // Single launch and flight.
    do_reset();
    press();
    tick();
    probe("spawn_tl", 323, 390, 1);
    probe("spawn_left", 322, 390, 0);
    probe("spawn_br", 326, 399, 1);
    probe("spawn_right", 327, 390, 0);
    probe("spawn_below", 323, 400, 0);
    repeat (10) tick();
    probe("fly_350", 323, 350, 1);
    probe("fly_350_right", 327, 350, 0);

    // Hit on the enemy at (300,200).
    do_reset();
    bus.enemy_x = 300; bus.enemy_y = 200; bus.enemyplane_exist = 1;
    press();
    tick();
    k = 0;
    while (bus.boom == 1'b0 && k < 60) begin tick(); k++; end
    check("hit_tick", k, 36);
    check("hit_count_1", int'(bus.hit_count), 1);
    probe("hit_slot_free", 323, 246, 0);
    nb = 0;
    while (bus.boom == 1'b1 && nb < 40) begin tick(); nb++; end
    check("boom_len", nb, 16);

    // Two bullets hit on one tick, a third passes through during boom.
    bus.enemy_x = 300; bus.enemy_y = 300; bus.enemyplane_exist = 0;
    press();
    tick();
    repeat (7) tick();
    press();
    tick();
    repeat (12) tick();
    probe("a_at_310", 323, 310, 1);
    probe("b_at_342", 323, 342, 1);
    bus.plane_y = 360; bus.enemyplane_exist = 1;
    press();
    tick();
    check("double_hit_count", int'(bus.hit_count), 2);
    check("double_hit_boom", int'(bus.boom), 1);
    probe("a_freed", 323, 306, 0);
    probe("b_freed", 323, 338, 0);
    probe("c_launched", 323, 350, 1);
    tick();
    probe("c_in_box", 323, 346, 1);
    repeat (16) tick();
    check("pass_through_hits", int'(bus.hit_count), 2);
    check("boom_over", int'(bus.boom), 0);

    // Five presses with four slots.
    do_reset();
    bus.enemyplane_exist = 0; bus.plane_x = 300; bus.plane_y = 400;
    press();
    tick();
    for (int p = 0; p < 4; p++) begin
      repeat (7) tick();
      press();
      tick();
    end
    probe("fifth_held", 323, 390, 0);
    while (n_tick < 98) tick();
    probe("slot0_low", 323, 2, 1);
    tick();
    probe("slot0_exit", 323, 2, 0);
    probe("fifth_not_yet", 323, 390, 0);
    tick();
    probe("fifth_launch", 323, 390, 1);

`ifdef AUTO_FIRE_EN
    do_reset();
    @(negedge clk); bus.fire = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      probe("auto_launch", 323, 399, (t == 1 || t == 9 || t == 17 || t == 25) ? 1 : 0);
    end
    bus.fire = 1'b0;
`endif

    // Reset during boom.
    do_reset();
    bus.enemy_x = 300; bus.enemy_y = 330; bus.enemyplane_exist = 1;
    press();
    tick();
    k = 0;
    while (bus.boom == 1'b0 && k < 10) begin tick(); k++; end
    check("quick_hit", k, 3);
    tick();
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_rst_boom", int'(bus.boom), 0);
    check("async_rst_hits", int'(bus.hit_count), 0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic checked by the model every cycle.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c == 2000) rst = 1'b0;
      if (c == 2002) rst = 1'b1;
      bus.move_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) bus.fire = ~bus.fire;
      if ($urandom_range(0, 63) == 0) begin
        bus.plane_x = 10'($urandom_range(0, 1000));
        bus.plane_y = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 12))
                                                  : 10'($urandom_range(100, 470));
      end
      if ($urandom_range(0, 127) == 0) begin
        bus.enemy_x = clip10(int'(bus.plane_x) + int'($urandom_range(0, 80)) - 40);
        bus.enemy_y = 10'($urandom_range(0, 300));
        bus.enemyplane_exist = ($urandom_range(0, 9) < 7);
      end
      r = int'($urandom_range(0, NB - 1));
      if (m_fly[r] != 0) begin
        bus.x = clip10(m_bx[r] + int'($urandom_range(0, 6)) - 1);
        bus.y = clip10(m_by[r] + int'($urandom_range(0, 12)) - 1);
      end else begin
        bus.x = 10'($urandom_range(0, 1023));
        bus.y = 10'($urandom_range(0, 1023));
      end
    end
    bus.move_tick = 0; bus.fire = 0;

    // Hit counter saturation.
    do_reset();
    bus.plane_x = 300; bus.plane_y = 400;
    bus.enemy_x = 300; bus.enemy_y = 330; bus.enemyplane_exist = 1;
    for (int h = 0; h < 258; h++) begin
      press();
      repeat (20) tick();
    end
    check("hit_saturate", int'(bus.hit_count), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
